// File: rtl/hazard_scoreboard.sv
// Read-after-write hazard detector for a 4-stage tail (ID->EX->MEM->WB): raises stall on
// unresolvable dependencies and registers EX-stage operand forwarding selects.
module hazard_scoreboard #(
   parameter bit FORWARDING = 1'b1,
   parameter bit RF_BYPASS  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [2:0]  id_rs,
   input  logic        id_rs_used,
   input  logic [2:0]  id_rt,
   input  logic        id_rt_used,
   input  logic [2:0]  id_rd,
   input  logic        id_we_reg,
   input  logic        id_is_load,
   input  logic        stall_ext,
   input  logic        flush,
   output logic        stall,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic [15:0] stall_count
);

   typedef struct packed {
      logic       v;
      logic [2:0] rd;
      logic       we;
   } tag_t;

   localparam logic [1:0] SelRf  = 2'b00;
   localparam logic [1:0] SelMem = 2'b01;
   localparam logic [1:0] SelWb  = 2'b10;

   // Only the EX slot needs the load flag; it is the sole source of load-use stalls.
   tag_t        ex_q, mem_q, wb_q, ex_d;
   logic        ex_ld_q, ex_ld_d;
   logic [1:0]  fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
   logic [15:0] stall_count_q;

   logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
   logic haz, bubble;

   function automatic logic tag_match(input tag_t t, input logic [2:0] src, input logic used,
                                      input logic valid);
      return t.v & t.we & (t.rd == src) & used & valid;
   endfunction

   always_comb begin
      ex_rs  = tag_match(ex_q,  id_rs, id_rs_used, id_valid);
      ex_rt  = tag_match(ex_q,  id_rt, id_rt_used, id_valid);
      mem_rs = tag_match(mem_q, id_rs, id_rs_used, id_valid);
      mem_rt = tag_match(mem_q, id_rt, id_rt_used, id_valid);
      wb_rs  = tag_match(wb_q,  id_rs, id_rs_used, id_valid);
      wb_rt  = tag_match(wb_q,  id_rt, id_rt_used, id_valid);

      // With bypass paths only a load in EX is unresolvable; without them anything in flight is.
      haz = ((ex_rs | ex_rt) & (ex_ld_q | ~FORWARDING))
          | ((mem_rs | mem_rt) & ~FORWARDING)
          | ((wb_rs | wb_rt) & ~RF_BYPASS);

      stall  = haz & ~flush;
      bubble = flush | stall | ~id_valid;

      ex_d    = '0;
      ex_ld_d = 1'b0;
      fwd_a_d = SelRf;
      fwd_b_d = SelRf;
      if (!bubble) begin
         ex_d    = '{v: 1'b1, rd: id_rd, we: id_we_reg};
         ex_ld_d = id_is_load;
         if (FORWARDING) begin
            if (ex_rs)       fwd_a_d = SelMem;
            else if (mem_rs) fwd_a_d = SelWb;
            if (ex_rt)       fwd_b_d = SelMem;
            else if (mem_rt) fwd_b_d = SelWb;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q          <= '0;
         ex_ld_q       <= 1'b0;
         mem_q         <= '0;
         wb_q          <= '0;
         fwd_a_q       <= SelRf;
         fwd_b_q       <= SelRf;
         stall_count_q <= '0;
      end else if (!stall_ext) begin
         wb_q    <= mem_q;
         mem_q   <= ex_q;
         ex_q    <= ex_d;
         ex_ld_q <= ex_ld_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
         end
      end
   end

   assign fwd_a_sel   = fwd_a_q;
   assign fwd_b_sel   = fwd_b_q;
   assign stall_count = stall_count_q;

endmodule
